// File: rtl/outbuff_axis_tx.sv
// ---------------------------------------------------------------------------
// outbuff_axis_tx
//
// Ping-pong output buffer and AXI-Stream master for the CNN accelerator's
// result path. The PE array writes result words into one bank. The other
// bank, which holds the previous tile, is streamed to DMA. A `start` pulse
// transmits `tile_words` words from address 0 of the selected bank. The last
// word carries `m_axis_tlast`.
//
// A credit-limited prefetch FIFO sits between the bank read port and the
// stream. It keeps one beat per cycle going under any `m_axis_tready`
// pattern. Reads are only issued while (fifo_count + inflight) < Fifo_Depth,
// so the FIFO can never overflow.
//
// Configuration macro:
//   OUTBUFF_OREG_EN  defined   -> bank output register enabled, read latency 2
//                    undefined -> registered read only, read latency 1
//
// Ports:
//   clk, rst           sole clock; synchronous active-high reset
//   wr_en/wr_strb/
//   wr_addr/wr_data    byte-masked write from the PE array
//   ping_pong_write    bank written (0 = bank0, 1 = bank1)
//   ping_pong_read     bank streamed, sampled on an accepted start
//   start, tile_words  transmit request and word count (0..2**Addr_Width)
//   busy, finished     status: busy until the one-cycle finished pulse
//   m_axis_*           AXI-Stream master
// ---------------------------------------------------------------------------
module outbuff_axis_tx #(
    parameter int Axi_Width  = 64,
    parameter int Addr_Width = 9,
    parameter int Fifo_Depth = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [Axi_Width/8-1:0] wr_strb,
    input  logic [Addr_Width-1:0]  wr_addr,
    input  logic [Axi_Width-1:0]   wr_data,
    input  logic                   ping_pong_write,
    input  logic                   ping_pong_read,
    input  logic                   start,
    input  logic [Addr_Width:0]    tile_words,
    output logic                   busy,
    output logic                   finished,
    output logic [Axi_Width-1:0]   m_axis_tdata,
    output logic                   m_axis_tvalid,
    output logic                   m_axis_tlast,
    input  logic                   m_axis_tready
);

    localparam int Words  = 2 ** Addr_Width;
    localparam int Strb_W = Axi_Width / 8;
    localparam int Ptr_W  = (Fifo_Depth > 1) ? $clog2(Fifo_Depth) : 1;
    localparam int Cnt_W  = $clog2(Fifo_Depth + 1) + 1;
    localparam logic [Addr_Width:0] One = (Addr_Width + 1)'(1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                state_q, state_d;
    logic                  rd_bank_q, rd_bank_d;
    logic [Addr_Width:0]   tile_words_q, tile_words_d;
    logic [Addr_Width:0]   rd_ptr_q, rd_ptr_d;
    logic                  busy_q, busy_d;
    logic                  finished_q, finished_d;
    logic                  p1_valid_q, p1_valid_d;
    logic                  p1_last_q, p1_last_d;
    logic [Cnt_W-1:0]      fifo_count_q, fifo_count_d;
    logic [Ptr_W-1:0]      fifo_head_q, fifo_head_d;
    logic [Ptr_W-1:0]      fifo_tail_q, fifo_tail_d;

    logic                  rd_issue;
    logic                  rd_last;
    logic                  credit_ok;
    logic [Addr_Width-1:0] rd_addr;
    logic [Axi_Width-1:0]  rd_data;
    logic [Cnt_W-1:0]      inflight;
    logic                  push;
    logic                  push_last;
    logic [Axi_Width-1:0]  push_data;
    logic                  pop;

    assign rd_addr = rd_ptr_q[Addr_Width-1:0];
    assign rd_last = (rd_ptr_q == tile_words_q - One);

    // -----------------------------------------------------------------------
    // Banks: byte-masked write, registered read-first read port.
    // -----------------------------------------------------------------------
    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic [Axi_Width-1:0] mem [Words];
        logic [Axi_Width-1:0] dout_q;

        // NOTE: bank storage and its read register have no reset; result data
        // is always rewritten by the PE array before it is streamed.
        always_ff @(posedge clk) begin
            if (wr_en && (ping_pong_write == 1'(b))) begin
                for (int i = 0; i < Strb_W; i++) begin
                    if (wr_strb[i]) mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
                end
            end
            // Same-edge read and write: the read samples the old word.
            if (rd_issue && (rd_bank_q == 1'(b))) dout_q <= mem[rd_addr];
        end
    end

    // The bank select only changes in IDLE, when the read pipeline is empty.
    assign rd_data = rd_bank_q ? g_bank[1].dout_q : g_bank[0].dout_q;

    // -----------------------------------------------------------------------
    // Read pipeline. The last-word tag travels alongside the data.
    // -----------------------------------------------------------------------
    assign p1_valid_d = rd_issue;
    assign p1_last_d  = rd_issue && rd_last;

`ifdef OUTBUFF_OREG_EN
    logic                 p2_valid_q, p2_valid_d;
    logic                 p2_last_q, p2_last_d;
    logic [Axi_Width-1:0] p2_data_q, p2_data_d;

    assign p2_valid_d = p1_valid_q;
    assign p2_last_d  = p1_last_q;
    assign p2_data_d  = rd_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            p2_valid_q <= 1'b0;
            p2_last_q  <= 1'b0;
        end else begin
            p2_valid_q <= p2_valid_d;
            p2_last_q  <= p2_last_d;
        end
    end

    always_ff @(posedge clk) begin
        p2_data_q <= p2_data_d;
    end

    assign inflight  = Cnt_W'(p1_valid_q) + Cnt_W'(p2_valid_q);
    assign push      = p2_valid_q;
    assign push_last = p2_last_q;
    assign push_data = p2_data_q;
`else
    assign inflight  = Cnt_W'(p1_valid_q);
    assign push      = p1_valid_q;
    assign push_last = p1_last_q;
    assign push_data = rd_data;
`endif

    assign credit_ok = (fifo_count_q + inflight) < Cnt_W'(Fifo_Depth);

    // -----------------------------------------------------------------------
    // Prefetch FIFO. Its head drives the stream directly.
    // -----------------------------------------------------------------------
    logic [Axi_Width-1:0] fifo_data_q [Fifo_Depth];
    logic                 fifo_last_q [Fifo_Depth];

    function automatic logic [Ptr_W-1:0] ptr_inc(input logic [Ptr_W-1:0] p);
        return (p == Ptr_W'(Fifo_Depth - 1)) ? '0 : p + Ptr_W'(1);
    endfunction

    assign m_axis_tvalid = (fifo_count_q != '0);
    // Data is zero while idle, so the stream is defined right after reset.
    assign m_axis_tdata  = m_axis_tvalid ? fifo_data_q[fifo_head_q] : '0;
    assign m_axis_tlast  = m_axis_tvalid ? fifo_last_q[fifo_head_q] : 1'b0;
    assign pop           = m_axis_tvalid && m_axis_tready;

    always_comb begin
        fifo_head_d  = fifo_head_q;
        fifo_tail_d  = fifo_tail_q;
        fifo_count_d = fifo_count_q;
        if (push) fifo_tail_d = ptr_inc(fifo_tail_q);
        if (pop)  fifo_head_d = ptr_inc(fifo_head_q);
        case ({push, pop})
            2'b10:   fifo_count_d = fifo_count_q + Cnt_W'(1);
            2'b01:   fifo_count_d = fifo_count_q - Cnt_W'(1);
            default: fifo_count_d = fifo_count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[fifo_tail_q] <= push_data;
            fifo_last_q[fifo_tail_q] <= push_last;
        end
    end

    // -----------------------------------------------------------------------
    // Control FSM
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so
        // no path leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        rd_bank_d    = rd_bank_q;
        tile_words_d = tile_words_q;
        rd_ptr_d     = rd_ptr_q;
        rd_issue     = 1'b0;
        finished_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rd_bank_d    = ping_pong_read;
                    tile_words_d = tile_words;
                    rd_ptr_d     = '0;
                    state_d      = (tile_words == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (credit_ok) begin
                    rd_issue = 1'b1;
                    rd_ptr_d = rd_ptr_q + One;
                    if (rd_last) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && m_axis_tlast) begin
                    state_d    = S_DONE;
                    finished_d = 1'b1;
                end
            end
            S_DONE: begin
                // An empty tile enters DONE without a pulse pending, so it
                // spends one extra cycle here to raise finished.
                if (finished_q) state_d    = S_IDLE;
                else            finished_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE) && !finished_d;
    end

    // NOTE: all state flops use non-blocking assignments, so each one samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rd_bank_q    <= 1'b0;
            tile_words_q <= '0;
            rd_ptr_q     <= '0;
            busy_q       <= 1'b0;
            finished_q   <= 1'b0;
            p1_valid_q   <= 1'b0;
            p1_last_q    <= 1'b0;
            fifo_count_q <= '0;
            fifo_head_q  <= '0;
            fifo_tail_q  <= '0;
        end else begin
            state_q      <= state_d;
            rd_bank_q    <= rd_bank_d;
            tile_words_q <= tile_words_d;
            rd_ptr_q     <= rd_ptr_d;
            busy_q       <= busy_d;
            finished_q   <= finished_d;
            p1_valid_q   <= p1_valid_d;
            p1_last_q    <= p1_last_d;
            fifo_count_q <= fifo_count_d;
            fifo_head_q  <= fifo_head_d;
            fifo_tail_q  <= fifo_tail_d;
        end
    end

    assign busy     = busy_q;
    assign finished = finished_q;

endmodule

// File: tb/tb_outbuff_axis_tx.sv
// ---------------------------------------------------------------------------
// tb_outbuff_axis_tx
//
// Directed and randomized bench for outbuff_axis_tx. The reference model is
// a plain array image of both banks. The expected stream for a tile is the
// selected bank's words 0..tile_words-1 as they stand when start is accepted.
// Concurrent writes during a tile only target the other bank.
// Honours OUTBUFF_OREG_EN for the first-beat latency.
// ---------------------------------------------------------------------------
module tb_outbuff_axis_tx;

    localparam int WORDS = 512;
`ifdef OUTBUFF_OREG_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [7:0]  wr_strb;
    logic [8:0]  wr_addr;
    logic [63:0] wr_data;
    logic        ping_pong_write;
    logic        ping_pong_read;
    logic        start;
    logic [9:0]  tile_words;
    logic        busy;
    logic        finished;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready;

    outbuff_axis_tx #(
        .Axi_Width (64),
        .Addr_Width(9),
        .Fifo_Depth(4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .wr_en          (wr_en),
        .wr_strb        (wr_strb),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .ping_pong_write(ping_pong_write),
        .ping_pong_read (ping_pong_read),
        .start          (start),
        .tile_words     (tile_words),
        .busy           (busy),
        .finished       (finished),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tready  (m_axis_tready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        bank;
        logic [8:0]  addr;
        logic [63:0] data;
        logic [7:0]  strb;
    } wr_t;

    wr_t         wq [$];
    logic [63:0] ref_mem [2][WORDS];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic q_write(input logic bank, input logic [8:0] addr,
                           input logic [63:0] data, input logic [7:0] strb);
        wr_t w;
        w.bank = bank; w.addr = addr; w.data = data; w.strb = strb;
        wq.push_back(w);
    endtask

    // Presents the next queued write for the coming edge and applies it to the model.
    task automatic drive_write_slot();
        wr_t w;
        if (wq.size() > 0) begin
            w = wq.pop_front();
            wr_en           = 1'b1;
            ping_pong_write = w.bank;
            wr_addr         = w.addr;
            wr_data         = w.data;
            wr_strb         = w.strb;
            for (int i = 0; i < 8; i++) begin
                if (w.strb[i]) ref_mem[w.bank][w.addr][i*8 +: 8] = w.data[i*8 +: 8];
            end
        end else begin
            wr_en = 1'b0;
        end
    endtask

    task automatic flush_writes();
        while (wq.size() > 0) begin
            drive_write_slot();
            tick();
        end
        wr_en = 1'b0;
    endtask

    // mode: 0 = tready always 1, 1 = pattern 1,0,0,1, 2 = random.
    // pulse_at >= 0 pulses start again that many cycles into the tile.
    // abort_at > 0 applies reset right after that many beats.
    task automatic run_tile(input logic bank, input int n, input int mode,
                            input bit timing_chk, input int pulse_at, input int abort_at);
        logic [63:0] expq [$];
        logic [63:0] prev_data;
        logic        prev_last;
        bit          fin_seen, prev_stall, aborted, r;
        int          beats, t_acc, first_c, last_c, fin_c, guard, budget;

        for (int i = 0; i < n; i++) expq.push_back(ref_mem[bank][i]);

        start          = 1'b1;
        ping_pong_read = bank;
        tile_words     = 10'(n);
        m_axis_tready  = 1'b1;
        drive_write_slot();
        tick();
        t_acc = cyc - 1;
        start          = 1'b0;
        ping_pong_read = ~bank;
        tile_words     = 10'($urandom_range(0, 512));
        check("busy_after_start", 64'(busy), 64'(1));

        beats = 0; first_c = -1; last_c = -1; fin_c = -1; guard = 0;
        fin_seen = 1'b0; prev_stall = 1'b0; aborted = 1'b0;
        prev_data = '0; prev_last = 1'b0;
        budget = 20 * n + 50;

        while (!fin_seen && !aborted && guard < budget) begin
            if (prev_stall) begin
                check("stall_tvalid", 64'(m_axis_tvalid), 64'(1));
                check("stall_tdata", m_axis_tdata, prev_data);
                check("stall_tlast", 64'(m_axis_tlast), 64'(prev_last));
            end
            if (finished) begin
                fin_seen = 1'b1;
                fin_c    = cyc;
            end
            case (mode)
                0:       r = 1'b1;
                1:       r = (guard % 4 == 0) || (guard % 4 == 3);
                default: r = 1'($urandom_range(0, 1));
            endcase
            if (m_axis_tvalid && r) begin
                if (beats < n) begin
                    check("beat_data", m_axis_tdata, expq[beats]);
                    check("beat_tlast", 64'(m_axis_tlast), 64'(beats == n - 1));
                end else begin
                    check("extra_beat_tvalid", 64'(m_axis_tvalid), 64'(0));
                end
                if (first_c < 0) first_c = cyc;
                last_c = cyc;
                beats++;
                if (abort_at > 0 && beats == abort_at) aborted = 1'b1;
            end
            prev_stall = m_axis_tvalid && !r;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
            start         = (guard == pulse_at);
            m_axis_tready = r;
            drive_write_slot();
            tick();
            guard++;
        end
        start = 1'b0;

        if (aborted) begin
            rst           = 1'b1;
            m_axis_tready = 1'b0;
            wr_en         = 1'b0;
            tick();
            rst = 1'b0;
            check("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
            check("rst_tdata", m_axis_tdata, 64'(0));
            check("rst_busy", 64'(busy), 64'(0));
            for (int k = 0; k < 8; k++) begin
                check("rst_no_finished", 64'(finished), 64'(0));
                check("rst_no_tvalid", 64'(m_axis_tvalid), 64'(0));
                tick();
            end
            return;
        end

        check("finished_seen", 64'(fin_seen), 64'(1));
        check("beat_count", 64'(beats), 64'(n));
        if (timing_chk) begin
            if (n == 0) begin
                check("fin_cycle_zero", 64'(fin_c), 64'(t_acc + 2));
            end else begin
                check("first_beat_cycle", 64'(first_c), 64'(t_acc + 2 + L));
                check("last_beat_cycle", 64'(last_c), 64'(t_acc + 1 + L + n));
                check("fin_cycle", 64'(fin_c), 64'(t_acc + 2 + L + n));
            end
        end

        m_axis_tready = 1'b1;
        check("busy_after_done", 64'(busy), 64'(0));
        for (int k = 0; k < 4; k++) begin
            check("post_no_tvalid", 64'(m_axis_tvalid), 64'(0));
            check("post_no_finished", 64'(finished), 64'(0));
            drive_write_slot();
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_strb = '0; wr_addr = '0; wr_data = '0;
        ping_pong_write = 1'b0; ping_pong_read = 1'b0; start = 1'b0;
        tile_words = '0; m_axis_tready = 1'b0;

        // Reset state
        tick();
        tick();
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_finished", 64'(finished), 64'(0));
        check("reset_tvalid", 64'(m_axis_tvalid), 64'(0));
        check("reset_tlast", 64'(m_axis_tlast), 64'(0));
        check("reset_tdata", m_axis_tdata, 64'(0));
        rst = 1'b0;
        tick();

        // Bank0 = 0x1000+i, full-rate stream with exact timing
        for (int i = 0; i < 16; i++) q_write(1'b0, 9'(i), 64'h1000 + 64'(i), 8'hFF);
        flush_writes();
        run_tile(1'b0, 16, 0, 1'b1, -1, 0);

        // Same tile under 1,0,0,1 backpressure while bank1 is filled
        for (int i = 0; i < 16; i++) q_write(1'b1, 9'(i), 64'hB000 + 64'(i), 8'hFF);
        run_tile(1'b0, 16, 1, 1'b0, -1, 0);
        flush_writes();
        run_tile(1'b1, 16, 0, 1'b1, -1, 0);

        // Empty tile
        run_tile(1'b0, 0, 0, 1'b1, -1, 0);

        // Fill the rest of both banks, then rewrite some words byte-wise
        for (int i = 16; i < WORDS; i++)
            q_write(1'b0, 9'(i), {$urandom(), $urandom()}, 8'hFF);
        for (int i = 0; i < WORDS; i++)
            q_write(1'b1, 9'(i), {$urandom(), $urandom()}, 8'hFF);
        for (int i = 0; i < 64; i++)
            q_write(1'b1, 9'(i), {$urandom(), $urandom()}, 8'($urandom_range(0, 255)));
        flush_writes();

        // Full-bank tiles
        run_tile(1'b1, 512, 2, 1'b0, -1, 0);
        run_tile(1'b0, 512, 0, 1'b1, -1, 0);

        // start pulsed while busy is ignored
        run_tile(1'b0, 16, 0, 1'b1, 3, 0);

        // Reset after 5 beats, then a clean restart from address 0
        run_tile(1'b0, 16, 0, 1'b0, -1, 5);
        run_tile(1'b0, 16, 0, 1'b1, -1, 0);

        // Random tiles with concurrent byte-masked writes to the other bank
        for (int t = 0; t < 8; t++) begin
            logic b;
            int   n, mode;
            b    = 1'($urandom_range(0, 1));
            n    = $urandom_range(1, 40);
            mode = $urandom_range(0, 2);
            for (int i = 0; i < n; i++)
                q_write(~b, 9'($urandom_range(0, WORDS - 1)), {$urandom(), $urandom()},
                        8'($urandom_range(0, 255)));
            run_tile(b, n, mode, mode == 0, -1, 0);
            flush_writes();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
